// File: rtl/irq_pending_arbiter_8.sv
// Eight-line interrupt pending register with a fixed-priority, non-preemptive
// single-offer arbiter (bit 7 highest) and a sticky overflow flag.
module irq_pending_arbiter_8 #(
    parameter bit LEVEL_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic [7:0] mask,
    input  logic       en,
    output logic [7:0] gnt_oh,
    output logic       gnt_valid,
    input  logic       gnt_ready,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Highest set bit of v as a one-hot vector; zero when v is zero.
    function automatic logic [7:0] prio_onehot(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r = 8'h01 << i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [7:0] irq_d_r;
    logic [7:0] pending_r;
    logic [7:0] gnt_oh_r;
    logic       gnt_valid_r;
    logic       overflow_r;

    logic [7:0] capture_s;
    logic [7:0] clear_s;
    logic [7:0] pending_s;
    logic [7:0] eligible_s;
    logic [7:0] gnt_oh_s;
    logic       gnt_valid_s;
    logic       overflow_set_s;

    // Capture events, acceptance clear and overflow detection; a capture beats a same-cycle clear.
    always_comb begin
        capture_s      = 8'h00;
        clear_s        = 8'h00;
        if (LEVEL_MODE) begin
            capture_s = irq;
        end else begin
            capture_s = irq & ~irq_d_r;
        end
        if ((state_r == OFFER) && gnt_ready) begin
            clear_s = gnt_oh_r;
        end else begin
            clear_s = 8'h00;
        end
        pending_s      = (pending_r & ~clear_s) | capture_s;
        eligible_s     = pending_r & ~mask;
        overflow_set_s = (!LEVEL_MODE) && (|(capture_s & pending_r & ~clear_s));
    end

    // Offer FSM next-state: an offer is held unchanged until it is accepted.
    always_comb begin
        state_s     = state_r;
        gnt_oh_s    = gnt_oh_r;
        gnt_valid_s = gnt_valid_r;
        case (state_r)
            IDLE: begin
                if (en && (eligible_s != 8'h00)) begin
                    state_s     = OFFER;
                    gnt_oh_s    = prio_onehot(eligible_s);
                    gnt_valid_s = 1'b1;
                end else begin
                    state_s     = IDLE;
                    gnt_oh_s    = 8'h00;
                    gnt_valid_s = 1'b0;
                end
            end
            OFFER: begin
                if (gnt_ready) begin
                    state_s     = IDLE;
                    gnt_oh_s    = 8'h00;
                    gnt_valid_s = 1'b0;
                end else begin
                    state_s     = OFFER;
                    gnt_oh_s    = gnt_oh_r;
                    gnt_valid_s = gnt_valid_r;
                end
            end
            default: begin
                state_s     = IDLE;
                gnt_oh_s    = 8'h00;
                gnt_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides everything, including a live offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            irq_d_r     <= 8'h00;
            pending_r   <= 8'h00;
            gnt_oh_r    <= 8'h00;
            gnt_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            irq_d_r     <= irq;
            pending_r   <= pending_s;
            gnt_oh_r    <= gnt_oh_s;
            gnt_valid_r <= gnt_valid_s;
            overflow_r  <= overflow_r | overflow_set_s;
        end
    end

    assign gnt_oh    = gnt_oh_r;
    assign gnt_valid = gnt_valid_r;
    assign pending   = pending_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_irq_pending_arbiter_8.sv
// Directed bench: stimulus pushes expected grants into a queue, a negedge
// monitor pops them on each accepted offer and checks offer stability.
module tb_irq_pending_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] irq;
    logic [7:0] mask;
    logic       en;
    logic [7:0] gnt_oh;
    logic       gnt_valid;
    logic       gnt_ready;
    logic [7:0] pending;
    logic       overflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       mon_en  = 1'b0;
    logic       hold_r  = 1'b0;
    logic [7:0] held_r  = 8'h00;

    irq_pending_arbiter_8 #(.LEVEL_MODE(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .mask      (mask),
        .en        (en),
        .gnt_oh    (gnt_oh),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: grant encoding, offer stability under backpressure, scoreboard pop on acceptance.
    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_encoding",
                  {31'd0, (gnt_valid ? $onehot(gnt_oh) : (gnt_oh == 8'h00))}, 32'd1);
            if (hold_r) begin
                check("offer_stable", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, held_r});
            end
            if (gnt_valid && gnt_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {24'd0, gnt_oh}, 32'd0);
                end else begin
                    check("grant", {24'd0, gnt_oh}, {24'd0, exp_q.pop_front()});
                end
            end
            hold_r = gnt_valid && !gnt_ready && !rst;
            held_r = gnt_oh;
        end
    end

    initial begin
        rst = 1'b1; irq = 8'h00; mask = 8'h00; en = 1'b1; gnt_ready = 1'b0;
        tick(); tick();
        check("rst_gnt_oh",    {24'd0, gnt_oh},  32'd0);
        check("rst_gnt_valid", {31'd0, gnt_valid}, 32'd0);
        check("rst_pending",   {24'd0, pending}, 32'd0);
        check("rst_overflow",  {31'd0, overflow}, 32'd0);
        mon_en = 1'b1;

        // Single request: capture at edge k, offer after k+1, accepted immediately.
        rst = 1'b0; irq = 8'h10; gnt_ready = 1'b1; exp_q.push_back(8'h10);
        tick();
        check("single_pending", {24'd0, pending}, 32'h10);
        check("single_novalid", {31'd0, gnt_valid}, 32'd0);
        irq = 8'h00;
        tick();
        check("single_latency", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h10});
        tick();
        check("single_cleared", {23'd0, gnt_valid, pending}, 32'd0);
        tick();
        check("single_one_cycle", {31'd0, gnt_valid}, 32'd0);

        // Priority with backpressure: 0x80 held, then 0x01 after one idle cycle.
        gnt_ready = 1'b0; irq = 8'h81; exp_q.push_back(8'h80); exp_q.push_back(8'h01);
        tick();
        irq = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("prio_hold", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h80});
            tick();
        end
        gnt_ready = 1'b1;
        tick();
        check("prio_gap", {23'd0, gnt_valid, pending}, {23'd0, 1'b0, 8'h01});
        tick();
        check("prio_second", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h01});
        tick();
        check("prio_drained", {24'd0, pending}, 32'd0);

        // Masked request is retained, then granted once unmasked.
        mask = 8'h04; irq = 8'h04;
        tick();
        irq = 8'h00;
        tick(); tick();
        check("mask_pending", {23'd0, gnt_valid, pending}, {23'd0, 1'b0, 8'h04});
        exp_q.push_back(8'h04); mask = 8'h00;
        tick();
        check("mask_offer", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h04});
        tick();
        check("mask_drained", {24'd0, pending}, 32'd0);

        // Overflow: second edge on bit 3 while its request is still pending.
        gnt_ready = 1'b0; irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        check("ovf_before", {31'd0, overflow}, 32'd0);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        check("ovf_set", {31'd0, overflow}, 32'd1);
        exp_q.push_back(8'h08); gnt_ready = 1'b1;
        tick(); tick(); tick();
        check("ovf_sticky", {23'd0, overflow, pending}, {23'd0, 1'b1, 8'h00});

        // Reset in the middle of an offer clears everything, no re-issue.
        gnt_ready = 1'b0; irq = 8'h20;
        tick();
        irq = 8'h00;
        tick();
        check("mid_offer", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h20});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out", {22'd0, overflow, gnt_valid, gnt_oh}, 32'd0);
        check("mid_rst_pending", {24'd0, pending}, 32'd0);
        gnt_ready = 1'b1;
        tick(); tick(); tick();
        check("mid_no_reissue", {31'd0, gnt_valid}, 32'd0);

        // New edge on bit 2 in its own acceptance cycle: set wins, no overflow.
        gnt_ready = 1'b0; irq = 8'h04; exp_q.push_back(8'h04); exp_q.push_back(8'h04);
        tick();
        irq = 8'h00;
        tick();
        gnt_ready = 1'b1; irq = 8'h04;
        tick();
        check("sdc_pending", {23'd0, overflow, pending}, {23'd0, 1'b0, 8'h04});
        irq = 8'h00;
        tick();
        check("sdc_regrant", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h04});
        tick();
        check("sdc_drained", {23'd0, overflow, pending}, 32'd0);

        // irq held high through reset release is seen as an edge.
        rst = 1'b1; irq = 8'h02;
        tick(); tick();
        check("hold_rst_pending", {24'd0, pending}, 32'd0);
        rst = 1'b0; exp_q.push_back(8'h02);
        tick();
        check("hold_captured", {24'd0, pending}, 32'h02);
        tick(); tick(); tick();
        check("hold_no_recapture", {23'd0, gnt_valid, pending}, 32'd0);
        irq = 8'h00;

        // en=0 blocks new offers; pending is kept.
        en = 1'b0; irq = 8'h40;
        tick();
        irq = 8'h00;
        tick(); tick();
        check("en_blocked", {23'd0, gnt_valid, pending}, {23'd0, 1'b0, 8'h40});
        exp_q.push_back(8'h40); en = 1'b1;
        tick();
        check("en_offer", {23'd0, gnt_valid, gnt_oh}, {23'd0, 1'b1, 8'h40});
        tick(); tick();

        check("queue_empty", exp_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
